i2c_adt7420_responder: RTL and testbench

- I2C target (slave) that emulates the ADT7420 register interface on a two-wire bus.
- Lets the existing ADT7420 I2C master be exercised on-board or in simulation without the physical sensor, using a temperature value supplied from fabric.
- Sits between the board SCL/SDA pins (open-drain, pulled up) and a fabric source of 16-bit temperature words.

---
 rtl/i2c_adt7420_responder_if.sv | 17 +
 rtl/i2c_adt7420_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_adt7420_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_adt7420_responder_if.sv
// -----------------------------------------------------------------------------
// i2c_adt7420_responder_if
// Two-wire bus signals seen by the ADT7420 responder.
//   scl_in       : raw SCL pin level (asynchronous to clk)
//   sda_in       : raw SDA pin level (asynchronous to clk)
//   sda_pull_low : 1 = target pulls SDA low, 0 = released (open-drain)
// The master modport is the bus side (pins / bus model); the slave modport is
// the responder.
// -----------------------------------------------------------------------------
interface i2c_adt7420_responder_if;
   logic scl_in;
   logic sda_in;
   logic sda_pull_low;

   modport master (output scl_in, output sda_in, input sda_pull_low);
   modport slave  (input scl_in, input sda_in, output sda_pull_low);
endinterface

// File: rtl/i2c_adt7420_responder.sv
// -----------------------------------------------------------------------------
// i2c_adt7420_responder
// I2C target emulating the ADT7420 register interface, so the ADT7420 master
// can be exercised without the physical sensor. The temperature comes from
// fabric and is snapshotted at each read address-ACK, so MSB/LSB are coherent.
// Ports:
//   clk, rst_n  : 100 MHz clock, synchronous active-low reset
//   bus         : scl_in / sda_in / sda_pull_low (slave modport)
//   temp_value  : ADT7420-format temperature word (bits [2:0] = 0)
//   cfg_out     : configuration register (pointer 0x03)
//   temp_read   : one-cycle pulse when the temperature MSB is loaded for TX
//   busy        : high from a valid START until STOP
// Register map (read): 00 temp MSB, 01 temp LSB, 02 status=0, 03 cfg,
//   0B device ID, others 0. Writes only land in 03. HOLD_CYC must be >= 1.
// -----------------------------------------------------------------------------
module i2c_adt7420_responder #(
   parameter logic [6:0]  I2C_ADDR = 7'h4B,
   parameter int unsigned HOLD_CYC = 3,
   parameter logic [7:0]  DEV_ID   = 8'hCB,
   parameter logic [7:0]  CFG_RST  = 8'h00
) (
   input  logic                          clk,
   input  logic                          rst_n,
   i2c_adt7420_responder_if.slave        bus,
   input  logic [15:0]                   temp_value,
   output logic [7:0]                    cfg_out,
   output logic                          temp_read,
   output logic                          busy
);

   localparam int HW = $clog2(HOLD_CYC + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, RD_BYTE, RD_ACK, WAIT_STOP
   } state_e;

   state_e        state_q, state_d;
   logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
   logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
   logic [3:0]    cnt_q, cnt_d;         // bit index in byte; 8/9 = ACK clock
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    ptr_q, ptr_d;
   logic [7:0]    cfg_q, cfg_d;
   logic [15:0]   shadow_q, shadow_d;
   logic          rw_q, rw_d;
   logic          drv_nxt_q, drv_nxt_d; // SDA level to apply when hold expires
   logic [HW-1:0] hold_q, hold_d;
   logic          sda_pull_q, sda_pull_d;
   logic          temp_read_q, temp_read_d;

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte, ld_byte;
   logic [2:0] bit_idx;

   function automatic logic [7:0] map_byte(input logic [7:0] ptr, input logic [15:0] shd,
                                           input logic [7:0] cfg);
      case (ptr)
         8'h00:   map_byte = shd[15:8];
         8'h01:   map_byte = shd[7:0];
         8'h03:   map_byte = cfg;
         8'h0B:   map_byte = DEV_ID;
         default: map_byte = 8'h00;
      endcase
   endfunction

   // Edges are taken between the second sync stage and the previous-value flop.
   assign scl_rise  =  scl_s2_q & ~scl_prev_q;
   assign scl_fall  = ~scl_s2_q &  scl_prev_q;
   assign start_det =  scl_s2_q &  scl_prev_q &  sda_prev_q & ~sda_s2_q;
   assign stop_det  =  scl_s2_q &  scl_prev_q & ~sda_prev_q &  sda_s2_q;

   assign bus.sda_pull_low = sda_pull_q;
   assign cfg_out          = cfg_q;
   assign temp_read        = temp_read_q;
   assign busy             = (state_q != IDLE);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      scl_s1_d    = bus.scl_in;
      scl_s2_d    = scl_s1_q;
      scl_prev_d  = scl_s2_q;
      sda_s1_d    = bus.sda_in;
      sda_s2_d    = sda_s1_q;
      sda_prev_d  = sda_s2_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      ptr_d       = ptr_q;
      cfg_d       = cfg_q;
      shadow_d    = shadow_q;
      rw_d        = rw_q;
      drv_nxt_d   = drv_nxt_q;
      hold_d      = hold_q;
      sda_pull_d  = sda_pull_q;
      temp_read_d = 1'b0;
      rx_byte     = {shift_q[6:0], sda_s2_q};
      ld_byte     = 8'h00;
      bit_idx     = 3'(4'd7 - cnt_q);

      // Pending SDA change lands HOLD_CYC cycles after the SCL fall that scheduled it.
      if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
         if (hold_q == HW'(1)) sda_pull_d = drv_nxt_q;
      end

      if (stop_det) begin
         state_d    = IDLE;
         hold_d     = '0;
         sda_pull_d = 1'b0;
      end else if (start_det) begin
         state_d    = ADDR;
         cnt_d      = 4'd0;
         hold_d     = '0;
         sda_pull_d = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = rx_byte;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  rw_d    = sda_s2_q;
                  state_d = (rx_byte[7:1] == I2C_ADDR) ? ADDR_ACK : WAIT_STOP;
               end
            end
            ADDR_ACK: if (scl_rise) begin
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall) begin
               hold_d = HW'(HOLD_CYC);
               if (cnt_q == 4'd8) begin
                  drv_nxt_d = 1'b1;                  // ACK during 9th clock
               end else begin
                  cnt_d = 4'd0;
                  if (rw_q) begin
                     shadow_d    = temp_value;
                     ld_byte     = map_byte(ptr_q, temp_value, cfg_q);
                     tx_d        = ld_byte;
                     drv_nxt_d   = ~ld_byte[7];
                     temp_read_d = (ptr_q == 8'h00);
                     state_d     = RD_BYTE;
                  end else begin
                     drv_nxt_d = 1'b0;
                     state_d   = WR_PTR;
                  end
               end
            end
            WR_PTR, WR_DATA: if (scl_rise) begin
               if (cnt_q < 4'd8) shift_d = rx_byte;
               if (cnt_q == 4'd7) begin
                  if (state_q == WR_PTR)   ptr_d = rx_byte;
                  else if (ptr_q == 8'h03) cfg_d = rx_byte;
               end
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  hold_d    = HW'(HOLD_CYC);
                  drv_nxt_d = 1'b1;
               end else if (cnt_q == 4'd9) begin
                  hold_d    = HW'(HOLD_CYC);
                  drv_nxt_d = 1'b0;
                  cnt_d     = 4'd0;
                  state_d   = WR_DATA;
               end
            end
            RD_BYTE: if (scl_rise) begin
               cnt_d = cnt_q + 4'd1;
            end else if (scl_fall) begin
               hold_d = HW'(HOLD_CYC);
               if (cnt_q == 4'd8) begin
                  drv_nxt_d = 1'b0;                  // release for master's ACK
                  cnt_d     = 4'd0;
                  state_d   = RD_ACK;
               end else begin
                  drv_nxt_d = ~tx_q[bit_idx];
               end
            end
            RD_ACK: if (scl_rise) begin
               if (sda_s2_q) begin
                  state_d = WAIT_STOP;
               end else begin
                  ptr_d = ptr_q + 8'd1;
                  cnt_d = 4'd9;
               end
            end else if (scl_fall && cnt_q == 4'd9) begin
               ld_byte     = map_byte(ptr_q, shadow_q, cfg_q);
               tx_d        = ld_byte;
               hold_d      = HW'(HOLD_CYC);
               drv_nxt_d   = ~ld_byte[7];
               temp_read_d = (ptr_q == 8'h00);
               cnt_d       = 4'd0;
               state_d     = RD_BYTE;
            end
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_prev_q  <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_prev_q  <= 1'b1;
         cnt_q       <= 4'd0;
         shift_q     <= 8'h00;
         tx_q        <= 8'h00;
         ptr_q       <= 8'h00;
         cfg_q       <= CFG_RST;
         // NOTE: the shadow word is reset too so a read before any snapshot is deterministic.
         shadow_q    <= 16'h0000;
         rw_q        <= 1'b0;
         drv_nxt_q   <= 1'b0;
         hold_q      <= '0;
         sda_pull_q  <= 1'b0;
         temp_read_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         scl_s1_q    <= scl_s1_d;
         scl_s2_q    <= scl_s2_d;
         scl_prev_q  <= scl_prev_d;
         sda_s1_q    <= sda_s1_d;
         sda_s2_q    <= sda_s2_d;
         sda_prev_q  <= sda_prev_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ptr_q       <= ptr_d;
         cfg_q       <= cfg_d;
         shadow_q    <= shadow_d;
         rw_q        <= rw_d;
         drv_nxt_q   <= drv_nxt_d;
         hold_q      <= hold_d;
         sda_pull_q  <= sda_pull_d;
         temp_read_q <= temp_read_d;
      end
   end

endmodule

// File: tb/tb_i2c_adt7420_responder.sv
// -----------------------------------------------------------------------------
// tb_i2c_adt7420_responder
// Directed bench: a bit-level I2C master drives the responder through reads,
// writes, a foreign address, repeated START, coherent snapshot and a reset in
// the middle of a read byte. Open-drain SDA is modelled as a wired AND.
// -----------------------------------------------------------------------------
module tb_i2c_adt7420_responder;

   localparam int Q = 20;                 // clk cycles per quarter SCL bit

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic [15:0] temp_value = 16'h0C80;
   logic [7:0]  cfg_out;
   logic        temp_read;
   logic        busy;

   always #5 clk = ~clk;

   i2c_adt7420_responder_if bus_if();
   assign bus_if.scl_in = scl_m;
   assign bus_if.sda_in = sda_m & ~bus_if.sda_pull_low;

   i2c_adt7420_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_if),
      .temp_value (temp_value),
      .cfg_out    (cfg_out),
      .temp_read  (temp_read),
      .busy       (busy)
   );

   int   checks = 0;
   int   passes = 0;
   int   tr_cnt = 0;
   int   hi_viol = 0;
   bit   pulled_seen = 1'b0;
   bit   mon_en = 1'b0;
   logic scl_p = 1'b1;
   logic pull_p = 1'b0;

   // Bus monitor: temp_read pulses, any SDA pull, SDA changes while SCL high.
   always @(negedge clk) begin
      if (temp_read === 1'b1) tr_cnt++;
      if (bus_if.sda_pull_low === 1'b1) pulled_seen = 1'b1;
      if (mon_en && scl_p && scl_m && (bus_if.sda_pull_low !== pull_p)) hi_viol++;
      scl_p  = scl_m;
      pull_p = bus_if.sda_pull_low;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_q();
      repeat (Q) @(posedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_q();
      scl_m = 1'b1; wait_q(); wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      b = bus_if.sda_in;
      wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         read_bit(s);
         d[i] = s;
      end
      write_bit(~ack);
   endtask

   logic       ack;
   logic       s;
   logic [7:0] rd;
   logic [7:0] wdata;

   initial begin
      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_sda", bus_if.sda_pull_low, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_temp_read", temp_read, 1'b0);
      check("rst_cfg", cfg_out, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      repeat (10) @(posedge clk);
      mon_en = 1'b1;

      // Two-byte temperature read from pointer 0
      tr_cnt = 0;
      i2c_start();
      write_byte(8'h97, ack);
      check("rd_addr_ack", ack, 1'b1);
      check("rd_busy", busy, 1'b1);
      read_byte(1'b1, rd);
      check("rd_msb", rd, 8'h0C);
      read_byte(1'b0, rd);
      check("rd_lsb", rd, 8'h80);
      i2c_stop();
      wait_q();
      check("rd_temp_read_cnt", tr_cnt, 1);
      check("rd_busy_after_stop", busy, 1'b0);

      // Foreign address 0x48 write: never acknowledged
      pulled_seen = 1'b0;
      i2c_start();
      write_byte(8'h90, ack);
      check("foreign_ack", ack, 1'b0);
      write_byte(8'h55, ack);
      check("foreign_data_ack", ack, 1'b0);
      i2c_stop();
      wait_q();
      check("foreign_never_pulled", pulled_seen, 1'b0);
      check("foreign_idle", busy, 1'b0);

      // Pointer 0x0B, repeated START, device ID read
      i2c_start();
      write_byte(8'h96, ack);
      check("id_addr_ack", ack, 1'b1);
      write_byte(8'h0B, ack);
      check("id_ptr_ack", ack, 1'b1);
      i2c_start();
      write_byte(8'h97, ack);
      check("id_raddr_ack", ack, 1'b1);
      read_byte(1'b0, rd);
      check("id_value", rd, 8'hCB);
      i2c_stop();

      // Config write 0xA0 at pointer 0x03, bit-level timing of the update
      wdata = 8'hA0;
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'h03, ack);
      check("cfg_ptr_ack", ack, 1'b1);
      for (int i = 7; i >= 1; i--) write_bit(wdata[i]);
      check("cfg_before_bit8", cfg_out, 8'h00);
      write_bit(wdata[0]);
      check("cfg_after_bit8", cfg_out, 8'hA0);
      read_bit(s);
      check("cfg_data_ack", s, 1'b0);
      i2c_stop();
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'h97, ack);
      read_byte(1'b0, rd);
      check("cfg_readback", rd, 8'hA0);
      i2c_stop();

      // Snapshot coherence: temperature changes between MSB and LSB
      tr_cnt = 0;
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'h00, ack);
      i2c_start();
      write_byte(8'h97, ack);
      read_byte(1'b1, rd);
      check("snap_msb", rd, 8'h0C);
      temp_value = 16'hFF00;
      read_byte(1'b0, rd);
      check("snap_lsb", rd, 8'h80);
      i2c_stop();
      wait_q();
      check("snap_temp_read_cnt", tr_cnt, 1);

      // Reset during bit 5 of a read byte that drives 0 (0x80 from pointer 1)
      temp_value = 16'h0C80;
      i2c_start();
      write_byte(8'h96, ack);
      write_byte(8'h01, ack);
      i2c_start();
      write_byte(8'h97, ack);
      check("mid_addr_ack", ack, 1'b1);
      for (int i = 0; i < 4; i++) read_bit(s);
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      check("mid_bit5_driven", bus_if.sda_pull_low, 1'b1);
      mon_en = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_sda", bus_if.sda_pull_low, 1'b0);
      check("mid_rst_cfg", cfg_out, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      scl_m = 1'b0; wait_q();
      i2c_stop();
      wait_q();
      mon_en = 1'b1;
      tr_cnt = 0;
      i2c_start();
      write_byte(8'h97, ack);
      check("post_rst_addr_ack", ack, 1'b1);
      read_byte(1'b1, rd);
      check("post_rst_msb", rd, 8'h0C);
      read_byte(1'b0, rd);
      check("post_rst_lsb", rd, 8'h80);
      i2c_stop();
      wait_q();
      check("post_rst_temp_read_cnt", tr_cnt, 1);
      check("post_rst_busy", busy, 1'b0);

      check("sda_stable_while_scl_high", hi_viol, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
